// File: rtl/bus_gnrtr_n_rbtr.sv
`default_nettype none
// ============================================================================
// Module      : bus_gnrtr_n_rbtr
// Description : Multi-bus packet arbiter/interconnect. Each of `bits` buses
//               owns an independent round-robin arbiter that grants one
//               pending driver, pops its head packet, then pushes that packet
//               to the driver(s) named by the 8-bit destination ID held in
//               the packet's top byte. One packet takes 3 cycles per bus
//               (IDLE -> POP -> PUSH).
// Ports       : clk     - single clock, rising edge
//               reset   - synchronous, active-low reset
//               pndng   - [bits][drvrs] driver has a packet queued
//               push    - [bits][drvrs] one-cycle write strobe into driver
//               pop     - [bits][drvrs] one-cycle remove-head strobe
//               D_pop   - [bits][drvrs] head packet of each driver
//               D_push  - [bits][drvrs] packet offered, identical per bus
// Revision    : 1.0 - initial release
// ============================================================================
module bus_gnrtr_n_rbtr #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [bits-1:0][drvrs-1:0]                pndng,
    output logic [bits-1:0][drvrs-1:0]                push,
    output logic [bits-1:0][drvrs-1:0]                pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);

    // Index width; kept at least 1 bit so a single-driver bus still elaborates.
    localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    localparam logic [drvrs-1:0] c_one_hot0 = {{(drvrs-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus

        state_t               r_state;
        logic [PW-1:0]        r_rr;
        logic [PW-1:0]        r_src;
        logic [pckg_sz-1:0]   r_pkt;
        logic [drvrs-1:0]     r_pop;
        logic [drvrs-1:0]     r_push;
        logic [pckg_sz-1:0]   r_dpush;

        logic                 w_found;
        logic [PW-1:0]        w_gnt;
        logic [PW-1:0]        w_idx;
        logic [7:0]           w_dest;
        logic [drvrs-1:0]     w_push_vec;

        // Round-robin search: first pending driver starting at r_rr, wrapping.
        always_comb begin
            w_found = 1'b0;
            w_gnt   = '0;
            w_idx   = '0;
            for (int k = 0; k < drvrs; k++) begin
                w_idx = PW'((32'(r_rr) + k) % drvrs);
                if (!w_found && pndng[b][w_idx]) begin
                    w_found = 1'b1;
                    w_gnt   = w_idx;
                end
            end
        end

        // Destination decode. A valid unicast ID wins over broadcast in case
        // the broadcast code ever falls inside the driver range; anything
        // else produces no push and the packet is dropped.
        assign w_dest = r_pkt[pckg_sz-1 -: 8];

        always_comb begin
            w_push_vec = '0;
            for (int i = 0; i < drvrs; i++) begin
                if (32'(w_dest) < drvrs) begin
                    w_push_vec[i] = (32'(w_dest) == i);
                end else if (w_dest == broadcast) begin
                    w_push_vec[i] = (32'(r_src) != i);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_state <= S_IDLE;
                r_rr    <= '0;
                r_src   <= '0;
                r_pkt   <= '0;
                r_pop   <= '0;
                r_push  <= '0;
                r_dpush <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_push <= '0;
                        if (w_found) begin
                            r_pkt   <= D_pop[b][w_gnt];
                            r_src   <= w_gnt;
                            r_pop   <= c_one_hot0 << w_gnt;
                            r_rr    <= (32'(w_gnt) == drvrs - 1) ? '0 : w_gnt + 1'b1;
                            r_state <= S_POP;
                        end else begin
                            r_pop <= '0;
                        end
                    end
                    S_POP: begin
                        r_pop   <= '0;
                        r_dpush <= r_pkt;
                        r_push  <= w_push_vec;
                        r_state <= S_PUSH;
                    end
                    S_PUSH: begin
                        // Return to IDLE for one cycle so the popped driver
                        // can refresh pndng before the next grant.
                        r_push  <= '0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_pop   <= '0;
                        r_push  <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign pop[b]    = r_pop;
        assign push[b]   = r_push;
        assign D_push[b] = {drvrs{r_dpush}};

    end : g_bus

endmodule
`default_nettype wire

// File: tb/tb_bus_gnrtr_n_rbtr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_gnrtr_n_rbtr
// Description : Self-checking bench for bus_gnrtr_n_rbtr (1 bus, 4 drivers,
//               16-bit packets). Directed per-cycle vector table plus hand
//               sequences for reset, round-robin order and mid-flight reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_gnrtr_n_rbtr;

    localparam int BITS  = 1;
    localparam int DRVRS = 4;
    localparam int PSZ   = 16;

    logic                                  clk;
    logic                                  reset;
    logic [BITS-1:0][DRVRS-1:0]            pndng;
    logic [BITS-1:0][DRVRS-1:0]            push;
    logic [BITS-1:0][DRVRS-1:0]            pop;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]   D_pop;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]   D_push;

    int n_chk  = 0;
    int n_pass = 0;

    bus_gnrtr_n_rbtr #(
        .bits      (BITS),
        .drvrs     (DRVRS),
        .pckg_sz   (PSZ),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .push   (push),
        .pop    (pop),
        .D_pop  (D_pop),
        .D_push (D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       pn;
        logic [3:0][15:0] dp;
        logic [3:0]       e_pop;
        logic [3:0]       e_push;
        logic [15:0]      e_dpush;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Every D_push lane must carry the same value.
    task automatic check_outs(input string tag, input logic [3:0] e_pop,
                              input logic [3:0] e_push, input logic [15:0] e_dpush);
        logic [15:0] lanes_ok;
        lanes_ok = 16'd1;
        for (int i = 1; i < DRVRS; i++)
            if (D_push[0][i] !== D_push[0][0]) lanes_ok = 16'd0;
        check({tag, ".pop"},   {12'd0, pop[0]},  {12'd0, e_pop});
        check({tag, ".push"},  {12'd0, push[0]}, {12'd0, e_push});
        check({tag, ".dpush"}, D_push[0][0],     e_dpush);
        check({tag, ".lanes"}, lanes_ok,         16'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [3:0] pn, input logic [15:0] d3,
                                 input logic [15:0] d2, input logic [15:0] d1,
                                 input logic [15:0] d0, input logic [3:0] ep,
                                 input logic [3:0] eu, input logic [15:0] ed);
        vec_t v;
        v.pn = pn; v.dp = {d3, d2, d1, d0};
        v.e_pop = ep; v.e_push = eu; v.e_dpush = ed;
        return v;
    endfunction

    initial begin
        logic [3:0]  ep;
        logic [3:0]  eu;

        // Inputs applied before an edge; outputs expected just after it.
        // Table starts from a fresh reset (rr_ptr = 0).
        // Unicast: driver 1 -> driver 2
        vecs[0]  = mkv(4'b0010, 16'h0, 16'h0, 16'h0217, 16'h0, 4'b0010, 4'b0000, 16'h0000);
        vecs[1]  = mkv(4'b0000, 16'h0, 16'h0, 16'h0,    16'h0, 4'b0000, 4'b0100, 16'h0217);
        vecs[2]  = mkv(4'b0000, 16'h0, 16'h0, 16'h0,    16'h0, 4'b0000, 4'b0000, 16'h0217);
        // Broadcast from driver 0 (search starts at 2, wraps to 0)
        vecs[3]  = mkv(4'b0001, 16'h0, 16'h0, 16'h0, 16'hFF2A, 4'b0001, 4'b0000, 16'h0217);
        vecs[4]  = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b1110, 16'hFF2A);
        vecs[5]  = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'hFF2A);
        // Invalid destination from driver 3: popped, never pushed
        vecs[6]  = mkv(4'b1000, 16'h0711, 16'h0, 16'h0, 16'h0, 4'b1000, 4'b0000, 16'hFF2A);
        vecs[7]  = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'h0711);
        vecs[8]  = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'h0711);
        // Next grant proceeds normally: driver 2 -> driver 3
        vecs[9]  = mkv(4'b0100, 16'h0, 16'h0305, 16'h0, 16'h0, 4'b0100, 4'b0000, 16'h0711);
        vecs[10] = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b1000, 16'h0305);
        vecs[11] = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'h0305);
        // Self-addressed: driver 0 -> driver 0 (search from 3 wraps to 0)
        vecs[12] = mkv(4'b0001, 16'h0, 16'h0, 16'h0, 16'h0099, 4'b0001, 4'b0000, 16'h0305);
        vecs[13] = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0001, 16'h0099);
        vecs[14] = mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0,    4'b0000, 4'b0000, 16'h0099);

        // ---- Reset held 3 cycles with every driver pending ----
        reset = 1'b0;
        pndng = '1;
        D_pop = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_outs($sformatf("rst%0d", c), 4'b0000, 4'b0000, 16'h0000);
        end

        // ---- Release: round-robin with all pending, all sending to 0 ----
        reset = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            ep = ((c - 1) % 3 == 0) ? (4'b0001 << (((c - 1) / 3) % 4)) : 4'b0000;
            eu = ((c - 1) % 3 == 1) ? 4'b0001 : 4'b0000;
            check_outs($sformatf("rr%0d", c), ep, eu, 16'h0000);
        end

        // ---- Reset during POP: rr_ptr is 1 here, so grant goes to driver 1 ----
        D_pop[0][1] = 16'h0355;
        tick();
        check_outs("mid.grant", 4'b0010, 4'b0000, 16'h0000);
        reset = 1'b0;
        tick();
        check_outs("mid.rst", 4'b0000, 4'b0000, 16'h0000);
        reset = 1'b1;
        tick();
        check_outs("mid.pop0", 4'b0001, 4'b0000, 16'h0000);
        pndng = '0;
        tick();
        check_outs("mid.push", 4'b0000, 4'b0001, 16'h0000);
        tick();
        check_outs("mid.idle", 4'b0000, 4'b0000, 16'h0000);

        // ---- Fresh reset, then the vector table ----
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int v = 0; v < 15; v++) begin
            pndng[0] = vecs[v].pn;
            D_pop[0] = vecs[v].dp;
            tick();
            check_outs($sformatf("vec%0d", v), vecs[v].e_pop, vecs[v].e_push, vecs[v].e_dpush);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
